// File: rtl/bitmap_index_drain.sv
// Iterative priority encoder: drains a multi-hot bitmap into one index per output beat.
// Optional BITMAP_DRAIN_COUNT_EN adds out_remaining (bits left to emit, including the current beat).
module bitmap_index_drain #(
  parameter int WIDTH     = 64,
  parameter int LSB_FIRST = 1,
  parameter int TAG_WIDTH = 8,
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1,
  localparam int CW = $clog2(WIDTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     in_bitmap,
  input  logic [TAG_WIDTH-1:0] in_tag,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [IW-1:0]        out_index,
  output logic [TAG_WIDTH-1:0] out_tag,
  output logic                 out_last,
  output logic                 out_empty,
`ifdef BITMAP_DRAIN_COUNT_EN
  output logic [CW-1:0]        out_remaining,
`endif
  output logic                 out_valid,
  input  logic                 out_ready
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    EMPTY = 2'd2
  } state_t;

  state_t               state_reg, state_next;
  logic [WIDTH-1:0]     h_reg, h_next;
  logic [TAG_WIDTH-1:0] tag_reg, tag_next;

  logic [WIDTH-1:0]     sel;
  logic [IW-1:0]        enc_idx;
  logic                 one_left;
  logic                 last_int;
  logic                 ready_int;
  logic                 accept;

  // One-hot select of the winning bit: set, and no higher-priority bit set.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_sel
      if (LSB_FIRST != 0) begin : g_lsb
        if (gi == 0) begin : g_edge
          assign sel[gi] = h_reg[gi];
        end else begin : g_mid
          assign sel[gi] = h_reg[gi] & ~(|h_reg[gi-1:0]);
        end
      end else begin : g_msb
        if (gi == WIDTH - 1) begin : g_edge
          assign sel[gi] = h_reg[gi];
        end else begin : g_mid
          assign sel[gi] = h_reg[gi] & ~(|h_reg[WIDTH-1:gi+1]);
        end
      end
    end
  endgenerate

  // sel is one-hot (or zero), so OR-ing the indices yields the binary position.
  always_comb begin
    enc_idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (sel[i]) begin
        enc_idx = enc_idx | IW'(i);
      end
    end
  end

  assign one_left  = (h_reg != '0) && ((h_reg & ~sel) == '0);
  assign last_int  = (state_reg == EMPTY) || ((state_reg == DRAIN) && one_left);
  assign ready_int = !rst && ((state_reg == IDLE) || (last_int && out_ready));
  assign accept    = in_valid && ready_int;

  always_comb begin
    state_next = state_reg;
    h_next     = h_reg;
    tag_next   = tag_reg;
    case (state_reg)
      DRAIN: begin
        if (out_ready) begin
          h_next = h_reg & ~sel;
          if (one_left) begin
            state_next = IDLE;
          end
        end
      end
      EMPTY: begin
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: ;
    endcase
    // A load on the final beat overrides the drain-to-IDLE transition.
    if (accept) begin
      h_next     = in_bitmap;
      tag_next   = in_tag;
      state_next = (in_bitmap != '0) ? DRAIN : EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      h_reg     <= '0;
      tag_reg   <= '0;
    end else begin
      state_reg <= state_next;
      h_reg     <= h_next;
      tag_reg   <= tag_next;
    end
  end

`ifdef BITMAP_DRAIN_COUNT_EN
  logic [CW-1:0] rem_reg, rem_next;

  function automatic logic [CW-1:0] popcount(input logic [WIDTH-1:0] v);
    logic [CW-1:0] c;
    c = '0;
    for (int i = 0; i < WIDTH; i++) begin
      c = c + CW'(v[i]);
    end
    return c;
  endfunction

  always_comb begin
    rem_next = rem_reg;
    if ((state_reg == DRAIN) && out_ready) begin
      rem_next = rem_reg - CW'(1);
    end
    if (accept) begin
      rem_next = popcount(in_bitmap);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rem_reg <= '0;
    end else begin
      rem_reg <= rem_next;
    end
  end

  assign out_remaining = rst ? '0 : rem_reg;
`endif

  // Outputs are forced quiet while reset is held, not only after the reset edge.
  assign in_ready  = ready_int;
  assign out_valid = !rst && (state_reg != IDLE);
  assign out_last  = !rst && last_int;
  assign out_empty = !rst && (state_reg == EMPTY);
  assign out_index = (!rst && (state_reg == DRAIN)) ? enc_idx : '0;
  assign out_tag   = rst ? '0 : tag_reg;

endmodule

// File: tb/tb_bitmap_index_drain.sv
// Scoreboard bench: three instances (W8 LSB-first, W8 MSB-first, W5 LSB-first) share one stimulus stream.
module tb_bitmap_index_drain;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_bitmap;
  logic [7:0] in_tag;
  logic       in_valid;
  logic       out_ready;
  int         cyc = 0;

  logic       ir_a, ir_b, ir_c;
  logic       ov_a, ov_b, ov_c;
  logic       ol_a, ol_b, ol_c;
  logic       oe_a, oe_b, oe_c;
  logic [2:0] oi_a, oi_b, oi_c;
  logic [7:0] ot_a, ot_b, ot_c;
`ifdef BITMAP_DRAIN_COUNT_EN
  logic [3:0] or_a, or_b;
  logic [2:0] or_c;
`endif

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bitmap_index_drain #(.WIDTH(8), .LSB_FIRST(1), .TAG_WIDTH(8)) u_a (
    .clk(clk), .rst(rst), .in_bitmap(in_bitmap), .in_tag(in_tag), .in_valid(in_valid),
    .in_ready(ir_a), .out_index(oi_a), .out_tag(ot_a), .out_last(ol_a), .out_empty(oe_a),
`ifdef BITMAP_DRAIN_COUNT_EN
    .out_remaining(or_a),
`endif
    .out_valid(ov_a), .out_ready(out_ready));

  bitmap_index_drain #(.WIDTH(8), .LSB_FIRST(0), .TAG_WIDTH(8)) u_b (
    .clk(clk), .rst(rst), .in_bitmap(in_bitmap), .in_tag(in_tag), .in_valid(in_valid),
    .in_ready(ir_b), .out_index(oi_b), .out_tag(ot_b), .out_last(ol_b), .out_empty(oe_b),
`ifdef BITMAP_DRAIN_COUNT_EN
    .out_remaining(or_b),
`endif
    .out_valid(ov_b), .out_ready(out_ready));

  bitmap_index_drain #(.WIDTH(5), .LSB_FIRST(1), .TAG_WIDTH(8)) u_c (
    .clk(clk), .rst(rst), .in_bitmap(in_bitmap[4:0]), .in_tag(in_tag), .in_valid(in_valid),
    .in_ready(ir_c), .out_index(oi_c), .out_tag(ot_c), .out_last(ol_c), .out_empty(oe_c),
`ifdef BITMAP_DRAIN_COUNT_EN
    .out_remaining(or_c),
`endif
    .out_valid(ov_c), .out_ready(out_ready));

  typedef struct {
    int id;
    int idx;
    bit last;
    bit empty;
    int tag;
    int hs;
    int rem;
  } beat_t;

  beat_t sb[$];
  int    n_vec  = 0;
  int    n_miss = 0;

  task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Reference model: expected beats for one instance, handshakes from first_hs onward.
  task automatic push_beats(input int id, input int w, input bit lsb, input logic [7:0] bm,
                            input logic [7:0] tg, input int first_hs);
    int pc;
    int k;
    int i;
    pc = 0;
    k  = 0;
    for (int j = 0; j < w; j++) pc += int'(bm[j]);
    if (pc == 0) begin
      sb.push_back('{id, 0, 1'b1, 1'b1, int'(tg), first_hs, 0});
    end else begin
      for (int j = 0; j < w; j++) begin
        i = lsb ? j : (w - 1 - j);
        if (bm[i]) begin
          sb.push_back('{id, i, (k == pc - 1), 1'b0, int'(tg), first_hs + k, pc - k});
          k++;
        end
      end
    end
  endtask

  task automatic send(input logic [7:0] bm, input logic [7:0] tg, input int stall);
    bit ok;
    int p;
    ok = 1'b0;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (ir_a && ir_b && ir_c) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      check_val("in_ready_timeout", {29'd0, ir_a, ir_b, ir_c}, 32'd7);
      return;
    end
    in_bitmap = bm;
    in_tag    = tg;
    in_valid  = 1'b1;
    @(posedge clk);
    #1;
    p        = cyc;
    in_valid = 1'b0;
    push_beats(0, 8, 1'b1, bm, tg, p + 1 + stall);
    push_beats(1, 8, 1'b0, bm, tg, p + 1 + stall);
    push_beats(2, 5, 1'b1, bm, tg, p + 1 + stall);
    $display("send: bitmap=%02h tag=%02h accepted at cycle %0d stall=%0d", bm, tg, p, stall);
    if (stall > 0) begin
      out_ready = 1'b0;
      repeat (stall) @(posedge clk);
      #1;
      out_ready = 1'b1;
    end
  endtask

  task automatic mon(input int id, input logic v, input logic [7:0] idx, input logic last,
                     input logic empty, input logic [7:0] tg, input logic [7:0] rem);
    int    pos;
    beat_t e;
    pos = -1;
    for (int i = 0; i < sb.size(); i++) begin
      if (sb[i].id == id) begin
        pos = i;
        break;
      end
    end
    if (pos < 0) begin
      if (v) check_val($sformatf("spurious_valid[%0d]", id), {31'd0, v}, 32'd0);
      return;
    end
    e = sb[pos];
    if (!v) begin
      if (e.hs <= cyc + 1) begin
        check_val($sformatf("missing_beat[%0d]", id), {31'd0, v}, 32'd1);
        sb.delete(pos);
      end
      return;
    end
    check_val($sformatf("index[%0d]", id), {24'd0, idx}, e.idx);
    check_val($sformatf("last[%0d]", id), {31'd0, last}, {31'd0, e.last});
    check_val($sformatf("empty[%0d]", id), {31'd0, empty}, {31'd0, e.empty});
    check_val($sformatf("tag[%0d]", id), {24'd0, tg}, e.tag);
`ifdef BITMAP_DRAIN_COUNT_EN
    check_val($sformatf("remaining[%0d]", id), {24'd0, rem}, e.rem);
`else
    if (rem !== 8'd0) $display("note: unexpected remaining input %0h", rem);
`endif
    if (out_ready) begin
      check_val($sformatf("hs_cycle[%0d]", id), cyc + 1, e.hs);
      $display("beat[%0d]: index=%0d last=%0b empty=%0b tag=%02h cycle=%0d",
               id, idx, last, empty, tg, cyc + 1);
      sb.delete(pos);
    end
  endtask

`ifdef BITMAP_DRAIN_COUNT_EN
  always @(negedge clk) mon(0, ov_a, {5'd0, oi_a}, ol_a, oe_a, ot_a, {4'd0, or_a});
  always @(negedge clk) mon(1, ov_b, {5'd0, oi_b}, ol_b, oe_b, ot_b, {4'd0, or_b});
  always @(negedge clk) mon(2, ov_c, {5'd0, oi_c}, ol_c, oe_c, ot_c, {5'd0, or_c});
`else
  always @(negedge clk) mon(0, ov_a, {5'd0, oi_a}, ol_a, oe_a, ot_a, 8'd0);
  always @(negedge clk) mon(1, ov_b, {5'd0, oi_b}, ol_b, oe_b, ot_b, 8'd0);
  always @(negedge clk) mon(2, ov_c, {5'd0, oi_c}, ol_c, oe_c, ot_c, 8'd0);
`endif

  initial begin
    logic [7:0] bm;
    rst       = 1'b1;
    in_bitmap = 8'd0;
    in_tag    = 8'd0;
    in_valid  = 1'b0;
    out_ready = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_in_ready", {29'd0, ir_a, ir_b, ir_c}, 32'd0);
    check_val("rst_out_valid", {29'd0, ov_a, ov_b, ov_c}, 32'd0);
    check_val("rst_last_empty", {26'd0, ol_a, ol_b, ol_c, oe_a, oe_b, oe_c}, 32'd0);
    check_val("rst_index", {23'd0, oi_a, oi_b, oi_c}, 32'd0);
    check_val("rst_tag", {8'd0, ot_a, ot_b, ot_c}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_val("idle_out_valid", {29'd0, ov_a, ov_b, ov_c}, 32'd0);
    check_val("idle_in_ready", {29'd0, ir_a, ir_b, ir_c}, 32'd7);

    // Ascending / descending drain, backpressure, all-zero, back-to-back
    send(8'b1001_0110, 8'h05, 0);
    send(8'hF0, 8'h11, 3);
    send(8'h00, 8'h2A, 0);
    send(8'h81, 8'h33, 0);
    send(8'h01, 8'h44, 0);

    // Reset after the first beat discards the remaining bits
    send(8'h11, 8'h3C, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    check_val("midrst_out_valid", {29'd0, ov_a, ov_b, ov_c}, 32'd0);
    check_val("midrst_in_ready", {29'd0, ir_a, ir_b, ir_c}, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_val("post_rst_out_valid", {29'd0, ov_a, ov_b, ov_c}, 32'd0);
    send(8'h04, 8'h77, 0);

    // Random traffic, including zero bitmaps and short stalls
    for (int n = 0; n < 24; n++) begin
      bm = 8'($urandom);
      if ($urandom_range(0, 4) == 0) bm = 8'd0;
      send(bm, 8'($urandom), int'($urandom_range(0, 2)));
    end

    for (int t = 0; t < 200 && sb.size() != 0; t++) @(posedge clk);
    @(negedge clk);
    check_val("scoreboard_drained", sb.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/bitmap_index_drain.md
Name: bitmap_index_drain

Overview:
Iterative priority-encoder engine. Accepts a WIDTH-bit request bitmap with a tag over a valid/ready handshake, then emits the index of every set bit, one per accepted output beat, in priority order. Used by the scheduler to turn a multi-hot eligibility vector into a serial stream of queue indices for the dequeue logic.

Parameters:
WIDTH, 64, bitmap width; any value >= 1, not required to be a power of two.
LSB_FIRST, 1, 1 = ascending index order (bit 0 first); 0 = descending order (bit WIDTH-1 first).
TAG_WIDTH, 8, width of the sideband tag carried from input to every output beat; must be >= 1.

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
in_bitmap  input  WIDTH  request bitmap
in_tag  input  TAG_WIDTH  sideband tag
in_valid  input  1  bitmap valid
in_ready  output  1  bitmap accepted when in_valid && in_ready
out_index  output  IW  index of the current set bit; IW = max(1, $clog2(WIDTH))
out_tag  output  TAG_WIDTH  tag of the bitmap being drained
out_last  output  1  final beat of this bitmap
out_empty  output  1  beat represents an all-zero bitmap
out_valid  output  1  output beat valid
out_ready  input  1  beat consumed when out_valid && out_ready

Behaviour:
- Reset: synchronous, active-high, on clk. While rst is high: in_ready=0, out_valid=0, out_last=0, out_empty=0, out_index=0, out_tag=0; the held bitmap is cleared and the FSM goes to IDLE. Reset mid-drain discards all remaining bits. No output beat appears on the cycle after rst deasserts.
- State: held bitmap register H (WIDTH bits), tag register, and FSM {IDLE, DRAIN, EMPTY}.
- IDLE: in_ready=1, out_valid=0. On accept of a nonzero in_bitmap: H<=in_bitmap, tag<=in_tag, go to DRAIN. On accept of in_bitmap==0: go to EMPTY.
- EMPTY: out_valid=1, out_empty=1, out_last=1, out_index=0. On out_ready, go to IDLE.
- DRAIN: out_valid=1. out_index = lowest set bit of H (LSB_FIRST=1) or highest set bit (LSB_FIRST=0). out_last=1 when H has exactly one bit set. out_empty=0. On out_ready, clear that bit in H. If out_last is also 1, go to IDLE.
- Latency: bitmap accepted in cycle N gives the first out_valid in cycle N+1. Throughput is one index per cycle while out_ready=1.
- Back-to-back: in_ready is also 1 in DRAIN or EMPTY when out_last && out_ready, which is a combinational out_ready->in_ready path. A bitmap accepted on the final beat loads directly and produces its first beat on the next cycle with no bubble. An all-zero bitmap accepted this way goes to EMPTY.
- Outputs come only from registers (H, tag, FSM). There is no combinational path from in_* to out_*.
- Backpressure: while out_valid && !out_ready, out_index, out_tag, out_last, out_empty and H are held stable.
- Encoder: combinational. The priority search over H is pure logic; the non-power-of-two upper range is padded with zeros. Index values >= WIDTH never appear.
- WIDTH=1: out_index is always 0, and every nonzero bitmap produces exactly one beat with out_last=1.

Optional Feature:
Macro BITMAP_DRAIN_COUNT_EN.
- Defined: adds output port out_remaining, width $clog2(WIDTH+1). On load it holds the popcount of the bitmap, including the current beat. It decrements by 1 on each DRAIN handshake and reads 1 when out_last=1. It reads 0 in EMPTY and IDLE, and resets to 0.
- Undefined: the port and the popcount logic are absent. All other behaviour is identical.

Test Plan:
1. WIDTH=8, LSB_FIRST=1, bitmap 8'b1001_0110, tag 8'h05, out_ready=1: beats with index 1, 2, 4, 7 on consecutive cycles starting N+1; out_last only on 7; out_tag=5 on all beats.
2. Same stimulus with LSB_FIRST=0: indices 7, 4, 2, 1; out_last on 1.
3. Backpressure: bitmap 8'hF0 with out_ready low for 3 cycles after the first beat: index 4 held stable for 4 cycles, then 5, 6, 7 follow; out_remaining 4 -> 3 -> 2 -> 1 (when the macro is defined).
4. All-zero bitmap, tag 8'h2A: exactly one beat with out_empty=1, out_last=1, out_index=0, tag 2A; then back to IDLE.
5. Back-to-back: bitmap 8'h81 followed immediately by 8'h01, out_ready=1: beats 0, 7, 0 on three consecutive cycles; the second bitmap is accepted on the cycle index 7 is delivered.
6. WIDTH=5, bitmap 5'b10001, rst asserted after the first beat: out_valid=0 the next cycle and index 4 is never emitted. A new bitmap 5'b00100 is then accepted and gives a single beat with index 2 and last=1.
